// File: rtl/rgb_led_arbiter.sv
// Shares one RGB LED between three requesters: arbitration, minimum hold, blink and PWM brightness.
// Optional macro RGB_ARB_ROUND_ROBIN_EN switches fixed priority (bit 0 highest) to round-robin.
module rgb_led_arbiter #(
  parameter int CLK_HZ      = 20000000,
  parameter int PWM_BITS    = 8,
  parameter int MIN_HOLD_MS = 100,
  parameter int BLINK_MS    = 500
) (
  input  logic                clk_20Mhz,
  input  logic                rst,
  input  logic [2:0]          req,
  input  logic [8:0]          req_color,
  input  logic [2:0]          req_blink,
  input  logic [PWM_BITS-1:0] duty,
  output logic [2:0]          grant,
  output logic                busy,
  output logic                pwm_red,
  output logic                pwm_green,
  output logic                pwm_blue,
  output logic [1:0]          state_dbg_o
);

  localparam int PRESC_MAX = CLK_HZ / 1000 - 1;
  localparam int PRESC_W   = (PRESC_MAX > 0) ? $clog2(PRESC_MAX + 1) : 1;
  localparam int HOLD_W    = (MIN_HOLD_MS > 0) ? $clog2(MIN_HOLD_MS + 1) : 1;
  localparam int BLINK_W   = (BLINK_MS > 0) ? $clog2(BLINK_MS + 1) : 1;

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESC_MAX);
  localparam logic [HOLD_W-1:0]  HOLD_MAX   = HOLD_W'(MIN_HOLD_MS);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_MS - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SHOW    = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [PRESC_W-1:0]  presc_q, presc_d;
  logic                ms_tick;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic                pwm_cmp;

  logic [1:0]          win_idx;
  logic [2:0]          win_color;
  logic                win_blink;

  logic [1:0]          winner_q, winner_d;
  logic [2:0]          color_q, color_d;
  logic                blink_q, blink_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [BLINK_W-1:0]  bcnt_q, bcnt_d;
  logic                phase_q, phase_d;

  logic [2:0]          grant_q, grant_d;
  logic                busy_q, busy_d;
  logic [2:0]          pwm_q, pwm_d;

  // Request/grant protocol: a requester holds req high to ask; grant (registered, one-hot)
  // acknowledges it, and the grant stays for at least the hold time even if req drops early.

  assign ms_tick   = (presc_q == PRESC_LAST);
  assign presc_d   = ms_tick ? '0 : presc_q + 1'b1;
  assign pwm_cnt_d = pwm_cnt_q + 1'b1;
  assign pwm_cmp   = (pwm_cnt_q < duty);

  always_ff @(posedge clk_20Mhz) begin
    if (rst) begin
      presc_q   <= '0;
      pwm_cnt_q <= '0;
    end else begin
      presc_q   <= presc_d;
      pwm_cnt_q <= pwm_cnt_d;
    end
  end

`ifdef RGB_ARB_ROUND_ROBIN_EN
  logic [1:0] last_q, last_d;

  // Search upward from the requester after the previous winner, wrapping at 3.
  always_comb begin
    win_idx = 2'd0;
    case (last_q)
      2'd0:    win_idx = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
      2'd1:    win_idx = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
      default: win_idx = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
    endcase
  end

  assign last_d = (state_q == S_IDLE && (|req)) ? win_idx : last_q;

  always_ff @(posedge clk_20Mhz) begin
    if (rst) last_q <= 2'd2;
    else     last_q <= last_d;
  end
`else
  always_comb begin
    win_idx = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
  end
`endif

  always_comb begin
    win_color = req_color[2:0];
    win_blink = req_blink[0];
    case (win_idx)
      2'd1:    begin win_color = req_color[5:3]; win_blink = req_blink[1]; end
      2'd2:    begin win_color = req_color[8:6]; win_blink = req_blink[2]; end
      default: begin win_color = req_color[2:0]; win_blink = req_blink[0]; end
    endcase
  end

  // FSM: state register
  always_ff @(posedge clk_20Mhz) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (|req) state_d = S_SHOW;
      S_SHOW:    if (!req[winner_q] && (hold_q == HOLD_MAX)) state_d = S_RELEASE;
      S_RELEASE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Latched winner data and the hold/blink timers
  always_comb begin
    winner_d = winner_q;
    color_d  = color_q;
    blink_d  = blink_q;
    hold_d   = hold_q;
    bcnt_d   = bcnt_q;
    phase_d  = phase_q;
    case (state_q)
      S_IDLE: begin
        if (|req) begin
          winner_d = win_idx;
          color_d  = win_color;
          blink_d  = win_blink;
          hold_d   = '0;
          bcnt_d   = '0;
          phase_d  = 1'b1;
        end
      end
      S_SHOW: begin
        if (ms_tick) begin
          if (hold_q != HOLD_MAX) hold_d = hold_q + 1'b1;
          if (blink_q) begin
            if (bcnt_q == BLINK_LAST) begin
              bcnt_d  = '0;
              phase_d = ~phase_q;
            end else begin
              bcnt_d = bcnt_q + 1'b1;
            end
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_20Mhz) begin
    if (rst) begin
      winner_q <= 2'd0;
      color_q  <= 3'b000;
      blink_q  <= 1'b0;
      hold_q   <= '0;
      bcnt_q   <= '0;
      phase_q  <= 1'b1;
    end else begin
      winner_q <= winner_d;
      color_q  <= color_d;
      blink_q  <= blink_d;
      hold_q   <= hold_d;
      bcnt_q   <= bcnt_d;
      phase_q  <= phase_d;
    end
  end

  // FSM: outputs, registered one cycle behind state and counters
  always_comb begin
    grant_d = 3'b000;
    busy_d  = (state_q != S_IDLE);
    pwm_d   = 3'b000;
    if (state_q == S_SHOW) begin
      grant_d = 3'b001 << winner_q;
      if (pwm_cmp && (!blink_q || phase_q)) pwm_d = color_q;
    end
  end

  always_ff @(posedge clk_20Mhz) begin
    if (rst) begin
      grant_q <= 3'b000;
      busy_q  <= 1'b0;
      pwm_q   <= 3'b000;
    end else begin
      grant_q <= grant_d;
      busy_q  <= busy_d;
      pwm_q   <= pwm_d;
    end
  end

  assign grant       = grant_q;
  assign busy        = busy_q;
  assign pwm_red     = pwm_q[0];
  assign pwm_green   = pwm_q[1];
  assign pwm_blue    = pwm_q[2];
  assign state_dbg_o = state_q;

endmodule

// File: tb/tb_rgb_led_arbiter.sv
// Bench for rgb_led_arbiter: directed scenarios plus random traffic against a timeline model.
module tb_rgb_led_arbiter;

  localparam int CLK_HZ      = 8000;
  localparam int PWM_BITS    = 3;
  localparam int MIN_HOLD_MS = 4;
  localparam int BLINK_MS    = 2;
  localparam int CPM         = CLK_HZ / 1000;

  logic                clk_20Mhz = 1'b0;
  logic                rst       = 1'b1;
  logic [2:0]          req       = 3'b000;
  logic [8:0]          req_color = 9'h000;
  logic [2:0]          req_blink = 3'b000;
  logic [PWM_BITS-1:0] duty      = '0;
  logic [2:0]          grant;
  logic                busy, pwm_red, pwm_green, pwm_blue;
  logic [1:0]          state_dbg_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_20Mhz = ~clk_20Mhz;

  rgb_led_arbiter #(
    .CLK_HZ(CLK_HZ), .PWM_BITS(PWM_BITS), .MIN_HOLD_MS(MIN_HOLD_MS), .BLINK_MS(BLINK_MS)
  ) dut (
    .clk_20Mhz(clk_20Mhz), .rst(rst), .req(req), .req_color(req_color),
    .req_blink(req_blink), .duty(duty), .grant(grant), .busy(busy),
    .pwm_red(pwm_red), .pwm_green(pwm_green), .pwm_blue(pwm_blue),
    .state_dbg_o(state_dbg_o)
  );

  // Reference timeline: cycles since reset, who owns the LED, and ms elapsed during the grant
  int         m_n = 0;
  int         m_owner = 0;
  int         m_last = 2;
  bit         m_show = 0;
  bit         m_rel = 0;
  int         m_ticks = 0;
  logic [2:0] m_col = 3'b000;
  bit         m_blk = 0;
  logic [2:0] exp_grant = 3'b000;
  logic       exp_busy = 1'b0;
  logic [2:0] exp_pwm = 3'b000;

  function automatic int pick_winner(input logic [2:0] r, input int last);
    int w;
    bit f;
    w = 0;
    f = 0;
`ifdef RGB_ARB_ROUND_ROBIN_EN
    for (int k = 1; k <= 3; k++) begin
      int i;
      i = (last + k) % 3;
      if (!f && r[i]) begin w = i; f = 1; end
    end
`else
    for (int k = 0; k < 3; k++) begin
      if (!f && r[k]) begin w = k; f = 1; end
    end
`endif
    return w;
  endfunction

  task automatic step();
    int pc;
    bit tick, cmp, ph_on;
    @(posedge clk_20Mhz);
    if (rst) begin
      m_n = 0; m_show = 0; m_rel = 0; m_ticks = 0; m_owner = 0;
      m_col = 3'b000; m_blk = 0; m_last = 2;
      exp_grant = 3'b000; exp_busy = 1'b0; exp_pwm = 3'b000;
    end else begin
      pc    = m_n % (1 << PWM_BITS);
      tick  = (m_n % CPM) == CPM - 1;
      cmp   = pc < int'(duty);
      ph_on = ((m_ticks / BLINK_MS) % 2) == 0;
      exp_grant = m_show ? 3'(1 << m_owner) : 3'b000;
      exp_busy  = m_show || m_rel;
      exp_pwm   = (m_show && cmp && (!m_blk || ph_on)) ? m_col : 3'b000;
      if (m_rel) begin
        m_rel = 0;
      end else if (m_show) begin
        if (!req[m_owner] && m_ticks >= MIN_HOLD_MS) begin
          m_show = 0;
          m_rel  = 1;
        end else if (tick) begin
          m_ticks++;
        end
      end else if (req != 3'b000) begin
        m_owner = pick_winner(req, m_last);
        m_last  = m_owner;
        m_show  = 1;
        m_ticks = 0;
        m_col   = req_color[3*m_owner +: 3];
        m_blk   = req_blink[m_owner];
      end
      m_n++;
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = 3'b000; req_color = 9'h000; req_blink = 3'b000; duty = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = 3'b000;
    for (int i = 0; i < 10; i++) begin
      step();
      n_checks++;
      if ({grant, busy, pwm_blue, pwm_green, pwm_red} !== 6'b0) begin
        n_fail++;
        $display("FAIL reset_idle cyc=%0d got=%b exp=000000", i, {grant, busy, pwm_blue, pwm_green, pwm_red});
      end
    end
    req = 3'b111;
    for (int i = 0; i < 2; i++) begin
      step();
      n_checks++;
      if (grant !== 3'b000) begin
        n_fail++;
        $display("FAIL reset_req_held got=%b exp=000", grant);
      end
    end
    rst = 1'b0;
    step();
    n_checks++;
    if (grant !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_release_c1 got=%b exp=000", grant);
    end
    step();
    n_checks++;
    if (grant !== 3'b001) begin
      n_fail++;
      $display("FAIL reset_release_c2 got=%b exp=001", grant);
    end
    for (int i = 0; i < 5; i++) step();
    rst = 1'b1;
    step();
    n_checks++;
    if ({grant, busy, pwm_blue, pwm_green, pwm_red} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_abort got=%b exp=000000", {grant, busy, pwm_blue, pwm_green, pwm_red});
    end
    rst = 1'b0;
    step();
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_no_release busy got=%b exp=0", busy);
    end
    req = 3'b000;
  endtask

  task automatic test_duty_red();
    int waited, red_n, other_n;
    do_reset();
    req = 3'b010; req_color = 9'b000_001_000; req_blink = 3'b000; duty = 3'd4;
    waited = 0;
    while (grant !== 3'b010 && waited < 10) begin
      step();
      waited++;
    end
    n_checks++;
    if (grant !== 3'b010) begin
      n_fail++;
      $display("FAIL duty_grant got=%b exp=010", grant);
    end
    red_n = 0;
    other_n = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      n_checks++;
      if ({grant, busy, pwm_blue, pwm_green, pwm_red} !== {exp_grant, exp_busy, exp_pwm}) begin
        n_fail++;
        $display("FAIL duty_model cyc=%0d got=%b exp=%b", i, {grant, busy, pwm_blue, pwm_green, pwm_red}, {exp_grant, exp_busy, exp_pwm});
      end
      red_n += int'(pwm_red);
      other_n += int'(pwm_green) + int'(pwm_blue);
    end
    n_checks++;
    if (red_n != 8) begin
      n_fail++;
      $display("FAIL duty_red_count got=%0d exp=8", red_n);
    end
    n_checks++;
    if (other_n != 0) begin
      n_fail++;
      $display("FAIL duty_gb_count got=%0d exp=0", other_n);
    end
  endtask

  task automatic test_hold_pulse();
    int g_n, rel_n;
    do_reset();
    req = 3'b010; req_color = 9'b000_111_000; duty = 3'd6;
    step();
    req = 3'b000;
    g_n = 0;
    rel_n = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      n_checks++;
      if ({grant, busy, pwm_blue, pwm_green, pwm_red} !== {exp_grant, exp_busy, exp_pwm}) begin
        n_fail++;
        $display("FAIL hold_model cyc=%0d got=%b exp=%b", i, {grant, busy, pwm_blue, pwm_green, pwm_red}, {exp_grant, exp_busy, exp_pwm});
      end
      if (grant === 3'b010) g_n++;
      if (busy === 1'b1 && grant === 3'b000) rel_n++;
    end
    n_checks++;
    if (g_n < MIN_HOLD_MS * CPM - CPM || g_n > MIN_HOLD_MS * CPM + 1) begin
      n_fail++;
      $display("FAIL hold_length got=%0d exp=%0d..%0d", g_n, MIN_HOLD_MS * CPM - CPM, MIN_HOLD_MS * CPM + 1);
    end
    n_checks++;
    if (rel_n != 1) begin
      n_fail++;
      $display("FAIL hold_release_cycles got=%0d exp=1", rel_n);
    end
  endtask

  task automatic test_blink();
    int blue_n, rg_n, run, max_run;
    do_reset();
    req = 3'b100; req_color = 9'b100_000_000; req_blink = 3'b100; duty = 3'd7;
    for (int i = 0; i < 40; i++) begin
      step();
      n_checks++;
      if ({grant, busy, pwm_blue, pwm_green, pwm_red} !== {exp_grant, exp_busy, exp_pwm}) begin
        n_fail++;
        $display("FAIL blink_model_a cyc=%0d got=%b exp=%b", i, {grant, busy, pwm_blue, pwm_green, pwm_red}, {exp_grant, exp_busy, exp_pwm});
      end
    end
    blue_n = 0; rg_n = 0; run = 0; max_run = 0;
    for (int i = 0; i < 64; i++) begin
      step();
      n_checks++;
      if ({grant, busy, pwm_blue, pwm_green, pwm_red} !== {exp_grant, exp_busy, exp_pwm}) begin
        n_fail++;
        $display("FAIL blink_model_b cyc=%0d got=%b exp=%b", i, {grant, busy, pwm_blue, pwm_green, pwm_red}, {exp_grant, exp_busy, exp_pwm});
      end
      blue_n += int'(pwm_blue);
      rg_n += int'(pwm_red) + int'(pwm_green);
      run = pwm_blue ? 0 : run + 1;
      if (run > max_run) max_run = run;
    end
    n_checks++;
    if (blue_n != 28) begin
      n_fail++;
      $display("FAIL blink_blue_count got=%0d exp=28", blue_n);
    end
    n_checks++;
    if (max_run != 17) begin
      n_fail++;
      $display("FAIL blink_off_run got=%0d exp=17", max_run);
    end
    n_checks++;
    if (rg_n != 0) begin
      n_fail++;
      $display("FAIL blink_rg_count got=%0d exp=0", rg_n);
    end
  endtask

  task automatic test_no_preempt();
    int gap, waited;
    logic [2:0] new_grant;
    do_reset();
    req = 3'b001; req_color = 9'b001_000_010; req_blink = 3'b000; duty = 3'd5;
    for (int i = 0; i < 3; i++) step();
    req = 3'b101;
    for (int i = 0; i < 50; i++) begin
      step();
      n_checks++;
      if (grant !== 3'b001) begin
        n_fail++;
        $display("FAIL no_preempt cyc=%0d got=%b exp=001", i, grant);
      end
    end
    req = 3'b100;
    gap = 0;
    waited = 0;
    new_grant = 3'b000;
    while (new_grant == 3'b000 && waited < 20) begin
      step();
      waited++;
      n_checks++;
      if ({grant, busy, pwm_blue, pwm_green, pwm_red} !== {exp_grant, exp_busy, exp_pwm}) begin
        n_fail++;
        $display("FAIL handover_model cyc=%0d got=%b exp=%b", waited, {grant, busy, pwm_blue, pwm_green, pwm_red}, {exp_grant, exp_busy, exp_pwm});
      end
      if (grant === 3'b000) gap++;
      else if (gap > 0) new_grant = grant;
    end
    n_checks++;
    if (new_grant !== 3'b100) begin
      n_fail++;
      $display("FAIL handover_grant got=%b exp=100", new_grant);
    end
    n_checks++;
    if (gap != 2) begin
      n_fail++;
      $display("FAIL handover_gap got=%0d exp=2", gap);
    end
  endtask

  task automatic test_arb_sequence();
    logic [2:0] exp_seq [4];
    int waited;
`ifdef RGB_ARB_ROUND_ROBIN_EN
    exp_seq = '{3'b001, 3'b010, 3'b100, 3'b001};
`else
    exp_seq = '{3'b001, 3'b001, 3'b001, 3'b001};
`endif
    do_reset();
    req_color = 9'b111_111_111; duty = 3'd3;
    for (int g = 0; g < 4; g++) begin
      req = 3'b111;
      waited = 0;
      while (grant === 3'b000 && waited < 10) begin
        step();
        waited++;
      end
      n_checks++;
      if (grant !== exp_seq[g]) begin
        n_fail++;
        $display("FAIL arb_seq idx=%0d got=%b exp=%b", g, grant, exp_seq[g]);
      end
      req = 3'b000;
      waited = 0;
      while (busy !== 1'b0 && waited < 60) begin
        step();
        waited++;
      end
      n_checks++;
      if (busy !== 1'b0) begin
        n_fail++;
        $display("FAIL arb_release_timeout idx=%0d busy=%b exp=0", g, busy);
      end
    end
  endtask

  task automatic test_duty_zero();
    do_reset();
    duty = '0; req_color = 9'h1FF; req_blink = 3'($urandom_range(0, 7));
    for (int i = 0; i < 60; i++) begin
      if (i % 20 == 0) req = 3'($urandom_range(1, 7));
      step();
      n_checks++;
      if ({pwm_blue, pwm_green, pwm_red} !== 3'b000 || busy !== exp_busy) begin
        n_fail++;
        $display("FAIL duty_zero cyc=%0d pwm=%b busy=%b exp pwm=000 busy=%b", i, {pwm_blue, pwm_green, pwm_red}, busy, exp_busy);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 7) == 0) req = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 15) == 0) req_color = 9'($urandom_range(0, 511));
      if ($urandom_range(0, 15) == 0) req_blink = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 31) == 0) duty = PWM_BITS'($urandom_range(0, (1 << PWM_BITS) - 1));
      step();
      n_checks++;
      if ({grant, busy, pwm_blue, pwm_green, pwm_red} !== {exp_grant, exp_busy, exp_pwm}) begin
        n_fail++;
        $display("FAIL random_model cyc=%0d got=%b exp=%b", i, {grant, busy, pwm_blue, pwm_green, pwm_red}, {exp_grant, exp_busy, exp_pwm});
      end
      n_checks++;
      if ($countones(grant) > 1) begin
        n_fail++;
        $display("FAIL random_onehot cyc=%0d got=%b exp=at most one bit", i, grant);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_duty_red();
    test_hold_pulse();
    test_blink();
    test_no_preempt();
    test_arb_sequence();
    test_duty_zero();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached, got=timeout exp=completion");
    $fatal(1, "watchdog");
  end

endmodule
